dcache_core_responder: RTL and testbench

Responder end of the core↔D-cache request/response bus: accepts core read requests, looks them up in a direct-mapped data store, and answers with `respcyc`/`resp`. Misses are forwarded to the next memory level over a second initiator-side bus, then filled. The block sits between the Memory pipeline stage (initiator) and the memory-side arbiter.

---
 rtl/dcache_core_responder.sv | 217 +++++++++++++++++++++
 tb/tb_dcache_core_responder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_core_responder.sv
// Core-side responder of the D-cache: direct-mapped lookup, miss forwarding and fill.
// Optional hit/miss counters are enabled with DCACHE_RESP_STATS_EN.
module dcache_core_responder #(
  parameter int LINES = 64,
  parameter int TAG_W = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             reqcyc,
  input  logic [63:0]      req,
  input  logic [TAG_W-1:0] reqtag,
  output logic             reqack,
  output logic             respcyc,
  output logic [63:0]      resp,
  output logic [TAG_W-1:0] resptag,
  input  logic             respack,
  output logic             memReqcyc,
  output logic [63:0]      memReq,
  input  logic             memReqack,
  input  logic             memRespcyc,
  input  logic [63:0]      memResp,
  output logic             memRespack
`ifdef DCACHE_RESP_STATS_EN
  ,
  output logic [31:0]      hitCount,
  output logic [31:0]      missCount
`endif
);

  localparam int IDX_W = $clog2(LINES);
  localparam int LT_W  = 61 - IDX_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MISS_REQ,
    S_MISS_WAIT,
    S_RESP
  } state_e;

  state_e             state_q, state_d;
  logic [60:0]        waddr_q, waddr_d;
  logic [TAG_W-1:0]   resptag_q, resptag_d;
  logic [63:0]        resp_q, resp_d;
  logic               reqack_q, reqack_d;
  logic               respcyc_q, respcyc_d;
  logic               memreqcyc_q, memreqcyc_d;
  logic [63:0]        memreq_q, memreq_d;
  logic               memrespack_q, memrespack_d;
  logic [LINES-1:0]   valid_q, valid_d;

  logic [LT_W-1:0]    tag_mem [LINES];
  logic [63:0]        data_mem [LINES];

  logic [IDX_W-1:0]   idx;
  logic [LT_W-1:0]    ltag;
  logic               hit;
  logic               is_read;
  logic               fill_we;
  logic               rd_hit;
  logic               rd_miss;

  // byte offset bits never reach the line lookup
  logic unused_req;
  assign unused_req = ^req[2:0];

  assign idx     = waddr_q[IDX_W-1:0];
  assign ltag    = waddr_q[60:IDX_W];
  assign hit     = valid_q[idx] && (tag_mem[idx] == ltag);
  assign is_read = resptag_q[TAG_W-1];

  always_comb begin
    state_d      = state_q;
    waddr_d      = waddr_q;
    resptag_d    = resptag_q;
    resp_d       = resp_q;
    reqack_d     = 1'b0;
    respcyc_d    = respcyc_q;
    memreqcyc_d  = memreqcyc_q;
    memreq_d     = memreq_q;
    memrespack_d = 1'b0;
    valid_d      = valid_q;
    fill_we      = 1'b0;
    rd_hit       = 1'b0;
    rd_miss      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (reqcyc) begin
          waddr_d   = req[63:3];
          resptag_d = reqtag;
          reqack_d  = 1'b1;
          state_d   = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (is_read) begin
          if (hit) begin
            rd_hit    = 1'b1;
            resp_d    = data_mem[idx];
            respcyc_d = 1'b1;
            state_d   = S_RESP;
          end else begin
            rd_miss     = 1'b1;
            memreqcyc_d = 1'b1;
            memreq_d    = {waddr_q, 3'b000};
            state_d     = S_MISS_REQ;
          end
        end else begin
          // writes only drop a stale copy; data goes elsewhere
          if (hit) begin
            valid_d[idx] = 1'b0;
          end
          resp_d    = '0;
          respcyc_d = 1'b1;
          state_d   = S_RESP;
        end
      end
      S_MISS_REQ: begin
        if (memReqack) begin
          memreqcyc_d = 1'b0;
          state_d     = S_MISS_WAIT;
        end
      end
      S_MISS_WAIT: begin
        if (memRespcyc) begin
          fill_we      = 1'b1;
          valid_d[idx] = 1'b1;
          resp_d       = memResp;
          memrespack_d = 1'b1;
          respcyc_d    = 1'b1;
          state_d      = S_RESP;
        end
      end
      S_RESP: begin
        if (respack) begin
          respcyc_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      waddr_q      <= '0;
      resptag_q    <= '0;
      resp_q       <= '0;
      reqack_q     <= 1'b0;
      respcyc_q    <= 1'b0;
      memreqcyc_q  <= 1'b0;
      memreq_q     <= '0;
      memrespack_q <= 1'b0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      waddr_q      <= waddr_d;
      resptag_q    <= resptag_d;
      resp_q       <= resp_d;
      reqack_q     <= reqack_d;
      respcyc_q    <= respcyc_d;
      memreqcyc_q  <= memreqcyc_d;
      memreq_q     <= memreq_d;
      memrespack_q <= memrespack_d;
      valid_q      <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_mem[idx]  <= ltag;
      data_mem[idx] <= memResp;
    end
  end

  assign reqack     = reqack_q;
  assign respcyc    = respcyc_q;
  assign resp       = resp_q;
  assign resptag    = resptag_q;
  assign memReqcyc  = memreqcyc_q;
  assign memReq     = memreq_q;
  assign memRespack = memrespack_q;

`ifdef DCACHE_RESP_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (rd_hit && (hit_cnt_q != 32'hFFFF_FFFF)) begin
      hit_cnt_d = hit_cnt_q + 32'd1;
    end
    if (rd_miss && (miss_cnt_q != 32'hFFFF_FFFF)) begin
      miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hitCount  = hit_cnt_q;
  assign missCount = miss_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = rd_hit ^ rd_miss;
`endif

endmodule

// File: tb/tb_dcache_core_responder.sv
// Directed bench for dcache_core_responder with a line-level cache model.
module tb_dcache_core_responder;
  localparam int LINES = 64;
  localparam int TAG_W = 13;

  logic             clk = 1'b0;
  logic             reset;
  logic             reqcyc;
  logic [63:0]      req;
  logic [TAG_W-1:0] reqtag;
  logic             reqack;
  logic             respcyc;
  logic [63:0]      resp;
  logic [TAG_W-1:0] resptag;
  logic             respack;
  logic             memReqcyc;
  logic [63:0]      memReq;
  logic             memReqack;
  logic             memRespcyc;
  logic [63:0]      memResp;
  logic             memRespack;
`ifdef DCACHE_RESP_STATS_EN
  logic [31:0]      hitCount;
  logic [31:0]      missCount;
`endif

  dcache_core_responder #(.LINES(LINES), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .reqcyc    (reqcyc),
    .req       (req),
    .reqtag    (reqtag),
    .reqack    (reqack),
    .respcyc   (respcyc),
    .resp      (resp),
    .resptag   (resptag),
    .respack   (respack),
    .memReqcyc (memReqcyc),
    .memReq    (memReq),
    .memReqack (memReqack),
    .memRespcyc(memRespcyc),
    .memResp   (memResp),
    .memRespack(memRespack)
`ifdef DCACHE_RESP_STATS_EN
    ,
    .hitCount  (hitCount),
    .missCount (missCount)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model: line index -> cached word address and data
  longint unsigned  m_addr [int];
  logic [63:0]      m_data [int];
  int               m_hits = 0;
  int               m_misses = 0;

  logic [63:0]      exp_resp = '0;
  logic [63:0]      exp_memreq = '0;
  logic [TAG_W-1:0] exp_tag = '0;
  logic [63:0]      last_resp;
  logic [63:0]      last_memreq;
  logic [TAG_W-1:0] last_tag;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (respcyc) begin
        chk("model_resp", resp, exp_resp);
        chk("model_resptag", 64'(resptag), 64'(exp_tag));
`ifdef DCACHE_RESP_STATS_EN
        chk("model_hitCount", 64'(hitCount), 64'(m_hits));
        chk("model_missCount", 64'(missCount), 64'(m_misses));
`endif
      end
      if (memReqcyc) begin
        chk("model_memReq", memReq, exp_memreq);
      end
    end
  end

  task automatic txn(input logic [63:0] a, input logic [TAG_W-1:0] tg,
                     input logic [63:0] fill, input int bp, input bit poke);
    int i;
    bit rd;
    bit hit;
    i   = int'((a >> 3) % LINES);
    rd  = tg[TAG_W-1];
    hit = m_addr.exists(i) && (m_addr[i] == longint'(a >> 3));
    exp_tag    = tg;
    exp_memreq = {a[63:3], 3'b000};
    if (!rd) begin
      exp_resp = '0;
      if (hit) m_addr.delete(i);
    end else if (hit) begin
      exp_resp = m_data[i];
      m_hits++;
    end else begin
      exp_resp  = fill;
      m_misses++;
      m_addr[i] = longint'(a >> 3);
      m_data[i] = fill;
    end
    @(negedge clk);
    reqcyc = 1'b1;
    req    = a;
    reqtag = tg;
    @(posedge clk); #1;
    chk("reqack", 64'(reqack), 64'd1);
    reqcyc = 1'b0;
    @(posedge clk); #1;
    last_memreq = '0;
    if (rd && !hit) begin
      chk("miss_memReqcyc", 64'(memReqcyc), 64'd1);
      chk("miss_respcyc", 64'(respcyc), 64'd0);
      last_memreq = memReq;
      repeat (2) begin
        @(posedge clk); #1;
        chk("memReqcyc_hold", 64'(memReqcyc), 64'd1);
      end
      memReqack = 1'b1;
      @(posedge clk); #1;
      memReqack = 1'b0;
      chk("memReqcyc_drop", 64'(memReqcyc), 64'd0);
      @(posedge clk); #1;
      memRespcyc = 1'b1;
      memResp    = fill;
      @(posedge clk); #1;
      memRespcyc = 1'b0;
      chk("fill_respcyc", 64'(respcyc), 64'd1);
      chk("fill_memRespack", 64'(memRespack), 64'd1);
    end else begin
      chk("hit_respcyc", 64'(respcyc), 64'd1);
      chk("hit_memReqcyc", 64'(memReqcyc), 64'd0);
    end
    last_resp = resp;
    last_tag  = resptag;
    for (int k = 0; k < bp; k++) begin
      reqcyc  = poke;
      respack = 1'b0;
      @(posedge clk); #1;
      chk("bp_respcyc", 64'(respcyc), 64'd1);
      chk("bp_reqack", 64'(reqack), 64'd0);
      chk("bp_resp_stable", resp, last_resp);
      chk("bp_tag_stable", 64'(resptag), 64'(last_tag));
      chk("bp_memRespack", 64'(memRespack), 64'd0);
    end
    respack = 1'b1;
    @(posedge clk); #1;
    respack = 1'b0;
    reqcyc  = 1'b0;
    chk("respcyc_fall", 64'(respcyc), 64'd0);
  endtask

  initial begin
    reset      = 1'b1;
    reqcyc     = 1'b0;
    req        = '0;
    reqtag     = '0;
    respack    = 1'b0;
    memReqack  = 1'b0;
    memRespcyc = 1'b0;
    memResp    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_reqack", 64'(reqack), 64'd0);
    chk("rst_respcyc", 64'(respcyc), 64'd0);
    chk("rst_memReqcyc", 64'(memReqcyc), 64'd0);
    chk("rst_memRespack", 64'(memRespack), 64'd0);
    chk("rst_resp", resp, 64'd0);
    chk("rst_resptag", 64'(resptag), 64'd0);
    chk("rst_memReq", memReq, 64'd0);
`ifdef DCACHE_RESP_STATS_EN
    chk("rst_hitCount", 64'(hitCount), 64'd0);
    chk("rst_missCount", 64'(missCount), 64'd0);
`endif
    reset = 1'b0;

    txn(64'h1000, 13'h1000, 64'hDEAD_BEEF, 2, 1'b0);
    chk("cold_memReq", last_memreq, 64'h1000);
    chk("cold_resp", last_resp, 64'hDEAD_BEEF);
    chk("cold_resptag", 64'(last_tag), 64'h1000);

    txn(64'h1004, 13'h1001, 64'h0, 0, 1'b0);
    chk("hit_resp", last_resp, 64'hDEAD_BEEF);
`ifdef DCACHE_RESP_STATS_EN
    chk("hit_hitCount", 64'(hitCount), 64'd1);
    chk("hit_missCount", 64'(missCount), 64'd1);
`endif

    txn(64'h1000 + 64'(8 * LINES), 13'h1002, 64'h1111_2222_3333_4444, 1, 1'b0);
    chk("conflict_memReq", last_memreq, 64'h1200);
    txn(64'h1000, 13'h1003, 64'hCAFE_F00D_0000_0001, 1, 1'b0);
    chk("conflict_reread", last_resp, 64'hCAFE_F00D_0000_0001);

    txn(64'h2000, 13'h1004, 64'hA5A5_A5A5_0000_2000, 1, 1'b0);
    txn(64'h2000, 13'h0005, 64'h0, 1, 1'b0);
    chk("wr_resp", last_resp, 64'd0);
    txn(64'h2000, 13'h1006, 64'h5A5A_5A5A_0000_2000, 1, 1'b0);
    chk("wr_refill_memReq", last_memreq, 64'h2000);
    txn(64'h3000, 13'h0007, 64'h0, 1, 1'b0);

    txn(64'h2000, 13'h1008, 64'h0, 5, 1'b1);
    chk("bp_resp", last_resp, 64'h5A5A_5A5A_0000_2000);

    exp_memreq = 64'h4008;
    @(negedge clk);
    reqcyc = 1'b1;
    req    = 64'h400C;
    reqtag = 13'h1009;
    @(posedge clk); #1;
    reqcyc = 1'b0;
    @(posedge clk); #1;
    chk("rm_memReqcyc", 64'(memReqcyc), 64'd1);
    memReqack = 1'b1;
    @(posedge clk); #1;
    memReqack = 1'b0;
    chk("rm_wait", 64'(memReqcyc), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_addr.delete();
    m_data.delete();
    m_hits   = 0;
    m_misses = 0;
    memRespcyc = 1'b1;
    memResp    = 64'hBAD0_BAD0_BAD0_BAD0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rm_memRespack", 64'(memRespack), 64'd0);
      chk("rm_respcyc", 64'(respcyc), 64'd0);
      chk("rm_reqack", 64'(reqack), 64'd0);
    end
    memRespcyc = 1'b0;
    txn(64'h1000, 13'h100A, 64'h0123_4567_89AB_CDEF, 1, 1'b0);
    chk("rm_refill_memReq", last_memreq, 64'h1000);
    chk("rm_refill_resp", last_resp, 64'h0123_4567_89AB_CDEF);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
